// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: opcodes, FSM encoding, slice-count helper.
// The optional Zero flag is enabled with the ALU_ZERO_FLAG_EN macro.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_n(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU digit: AND/OR or ripple add with B inverted for SUB/SLT.
// Exposes the carry into its top bit so the top level can form signed overflow.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  logic [2:0]       op,
  output logic [SLICE-1:0] r,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE-1:0] bx;
  logic [SLICE-1:0] sum;

  always_comb begin : chain
    logic c;
    bx       = ((op == OP_SUB) || (op == OP_SLT)) ? ~b : b;
    sum      = '0;
    c        = cin;
    c_msb_in = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) c_msb_in = c;
      sum[i] = a[i] ^ bx[i] ^ c;
      c      = (a[i] & bx[i]) | (c & (a[i] ^ bx[i]));
    end
    cout = c;
    case (op)
      OP_AND:                 r = a & b;
      OP_OR:                  r = a | b;
      OP_ADD, OP_SUB, OP_SLT: r = sum;
      default:                r = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Digit-serial WIDTH-bit ALU, SLICE bits per cycle LSB first, Start/Busy/Done handshake.
// Define ALU_ZERO_FLAG_EN to add the registered Zero output.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Vout,
  output logic             Set
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic             Zero
`endif
);

  localparam int N  = calc_n(WIDTH, SLICE);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);

  if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_slice
    $error("alu_serial: SLICE must divide WIDTH");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sh_q, result_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    k_q;
  logic             carry_q, cout_q, vout_q, set_q;
  logic             accept, last;

  logic [SLICE-1:0] slice_r;
  logic             slice_cout, slice_cmsb;
  logic [WIDTH-1:0] sum_full, res_c;
  logic             cout_c, vout_c, set_c, v_c, s_c;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a        (a_q[SLICE-1:0]),
    .b        (b_q[SLICE-1:0]),
    .cin      (carry_q),
    .op       (op_q),
    .r        (slice_r),
    .cout     (slice_cout),
    .c_msb_in (slice_cmsb)
  );

  assign accept = (state_q != RUN) && Start;
  assign last   = (state_q == RUN) && (k_q == K_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = Start ? RUN : IDLE;
      RUN:        if (k_q == K_LAST) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // New slice enters at the top; after N shifts the word is LSB-aligned.
  always_comb begin
    sum_full = sh_q >> SLICE;
    sum_full[WIDTH-1 -: SLICE] = slice_r;
  end

  always_comb begin
    v_c    = slice_cmsb ^ slice_cout;
    s_c    = sum_full[WIDTH-1] ^ v_c;
    res_c  = '0;
    cout_c = 1'b0;
    vout_c = 1'b0;
    set_c  = 1'b0;
    case (op_q)
      OP_AND, OP_OR: res_c = sum_full;
      OP_ADD: begin
        res_c  = sum_full;
        cout_c = slice_cout;
        vout_c = v_c;
      end
      OP_SUB: begin
        res_c  = sum_full;
        cout_c = slice_cout;
        vout_c = v_c;
        set_c  = s_c;
      end
      OP_SLT: begin
        res_c[0] = s_c;
        cout_c   = slice_cout;
        vout_c   = v_c;
        set_c    = s_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      sh_q     <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      vout_q   <= 1'b0;
      set_q    <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B;
      op_q    <= Op;
      k_q     <= '0;
      carry_q <= (Op == OP_SUB) || (Op == OP_SLT);
    end else if (state_q == RUN) begin
      a_q     <= a_q >> SLICE;
      b_q     <= b_q >> SLICE;
      carry_q <= slice_cout;
      sh_q    <= sum_full;
      k_q     <= k_q + CW'(1);
      if (last) begin
        result_q <= res_c;
        cout_q   <= cout_c;
        vout_q   <= vout_c;
        set_q    <= set_c;
      end
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge clk) begin
    if (reset)     zero_q <= 1'b0;
    else if (last) zero_q <= (res_c == '0);
  end
  assign Zero = zero_q;
`endif

  assign Busy   = (state_q == RUN);
  assign Done   = (state_q == DONE);
  assign Result = result_q;
  assign Cout   = cout_q;
  assign Vout   = vout_q;
  assign Set    = set_q;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: one DUT per SLICE in {8,1,4,32}, WIDTH=32.
// Zero-flag checks are compiled in when ALU_ZERO_FLAG_EN is defined.
module tb_alu_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        start [4];
  logic        busy  [4];
  logic        done  [4];
  logic        cout  [4];
  logic        vout  [4];
  logic        set   [4];
  logic [31:0] res   [4];
`ifdef ALU_ZERO_FLAG_EN
  logic        zero  [4];
`endif

  int nvec = 0;
  int nmis = 0;
  int nexp [4] = '{4, 32, 8, 1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    alu_serial #(
      .WIDTH (32),
      .SLICE ((g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32)
    ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .Start  (start[g]),
      .Op     (op),
      .A      (a),
      .B      (b),
      .Busy   (busy[g]),
      .Done   (done[g]),
      .Result (res[g]),
      .Cout   (cout[g]),
      .Vout   (vout[g]),
      .Set    (set[g])
`ifdef ALU_ZERO_FLAG_EN
      ,
      .Zero   (zero[g])
`endif
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on DUT d and return cycles from the Start edge to Done (-1 on timeout).
  task automatic run_op(input int d, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat);
    op = o; a = x; b = y;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    lat = 0;
    while (!done[d] && lat < 100) begin
      tick();
      lat++;
    end
    if (!done[d]) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    nvec++; if (busy[0] !== 1'b0) begin nmis++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
    nvec++; if (done[0] !== 1'b0) begin nmis++; $display("FAIL reset_done: got %b want 0", done[0]); end
    nvec++; if (res[0] !== 32'h0) begin nmis++; $display("FAIL reset_result: got %h want 0", res[0]); end
    nvec++; if ({cout[0], vout[0], set[0]} !== 3'b000) begin
      nmis++; $display("FAIL reset_flags: got %b want 000", {cout[0], vout[0], set[0]}); end
`ifdef ALU_ZERO_FLAG_EN
    nvec++; if (zero[0] !== 1'b0) begin nmis++; $display("FAIL reset_zero: got %b want 0", zero[0]); end
`endif
  endtask

  task automatic test_add();
    int lat;
    run_op(0, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    nvec++; if (lat !== 4) begin nmis++; $display("FAIL add_latency: got %0d want 4", lat); end
    nvec++; if (res[0] !== 32'h8000_0000) begin nmis++; $display("FAIL add_result: got %h want 80000000", res[0]); end
    nvec++; if ({cout[0], vout[0], set[0]} !== 3'b010) begin
      nmis++; $display("FAIL add_flags CVS: got %b want 010", {cout[0], vout[0], set[0]}); end
    tick();
    nvec++; if (done[0] !== 1'b0) begin nmis++; $display("FAIL add_done_pulse: got %b want 0", done[0]); end
    nvec++; if (res[0] !== 32'h8000_0000) begin nmis++; $display("FAIL add_hold: got %h want 80000000", res[0]); end
  endtask

  task automatic test_sub();
    int lat;
    run_op(0, 3'b110, 32'd5, 32'd7, lat);
    nvec++; if (res[0] !== 32'hFFFF_FFFE) begin nmis++; $display("FAIL sub_result: got %h want fffffffe", res[0]); end
    nvec++; if ({cout[0], vout[0], set[0]} !== 3'b001) begin
      nmis++; $display("FAIL sub_flags CVS: got %b want 001", {cout[0], vout[0], set[0]}); end
  endtask

  task automatic test_slt();
    int lat;
    run_op(0, 3'b111, 32'h8000_0000, 32'h0000_0001, lat);
    nvec++; if (res[0] !== 32'h1) begin nmis++; $display("FAIL slt1_result: got %h want 1", res[0]); end
    nvec++; if ({cout[0], vout[0], set[0]} !== 3'b111) begin
      nmis++; $display("FAIL slt1_flags CVS: got %b want 111", {cout[0], vout[0], set[0]}); end
    run_op(0, 3'b111, 32'h0000_0001, 32'h8000_0000, lat);
    nvec++; if (res[0] !== 32'h0) begin nmis++; $display("FAIL slt2_result: got %h want 0", res[0]); end
    nvec++; if ({cout[0], vout[0], set[0]} !== 3'b010) begin
      nmis++; $display("FAIL slt2_flags CVS: got %b want 010", {cout[0], vout[0], set[0]}); end
`ifdef ALU_ZERO_FLAG_EN
    nvec++; if (zero[0] !== 1'b1) begin nmis++; $display("FAIL slt2_zero: got %b want 1", zero[0]); end
`endif
  endtask

  task automatic test_logic();
    int lat;
    run_op(0, 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
    nvec++; if (res[0] !== 32'h00F0_00F0) begin nmis++; $display("FAIL and_result: got %h want 00f000f0", res[0]); end
    nvec++; if ({cout[0], vout[0], set[0]} !== 3'b000) begin
      nmis++; $display("FAIL and_flags CVS: got %b want 000", {cout[0], vout[0], set[0]}); end
    run_op(0, 3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat);
    nvec++; if (res[0] !== 32'hFFF0_FFF0) begin nmis++; $display("FAIL or_result: got %h want fff0fff0", res[0]); end
    nvec++; if ({cout[0], vout[0], set[0]} !== 3'b000) begin
      nmis++; $display("FAIL or_flags CVS: got %b want 000", {cout[0], vout[0], set[0]}); end
`ifdef ALU_ZERO_FLAG_EN
    nvec++; if (zero[0] !== 1'b0) begin nmis++; $display("FAIL or_zero: got %b want 0", zero[0]); end
`endif
    run_op(0, 3'b000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, lat);
    nvec++; if (res[0] !== 32'h0) begin nmis++; $display("FAIL and0_result: got %h want 0", res[0]); end
`ifdef ALU_ZERO_FLAG_EN
    nvec++; if (zero[0] !== 1'b1) begin nmis++; $display("FAIL and0_zero: got %b want 1", zero[0]); end
`endif
  endtask

  task automatic test_unsupported();
    int lat;
    run_op(0, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    run_op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    nvec++; if (lat !== 4) begin nmis++; $display("FAIL unsup_latency: got %0d want 4", lat); end
    nvec++; if (res[0] !== 32'h0) begin nmis++; $display("FAIL unsup_result: got %h want 0", res[0]); end
    nvec++; if ({cout[0], vout[0], set[0]} !== 3'b000) begin
      nmis++; $display("FAIL unsup_flags CVS: got %b want 000", {cout[0], vout[0], set[0]}); end
  endtask

  task automatic test_start_while_busy();
    int lat;
    op = 3'b010; a = 32'd3; b = 32'd4;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    nvec++; if (busy[0] !== 1'b1) begin nmis++; $display("FAIL busy_after_start: got %b want 1", busy[0]); end
    lat = 0;
    tick(); lat++;
    op = 3'b110; a = 32'd100; b = 32'd200;
    start[0] = 1'b1;
    tick(); lat++;
    start[0] = 1'b0;
    while (!done[0] && lat < 100) begin
      tick();
      lat++;
    end
    nvec++; if (lat !== 4) begin nmis++; $display("FAIL ignore_latency: got %0d want 4", lat); end
    nvec++; if (res[0] !== 32'd7) begin nmis++; $display("FAIL ignore_result: got %h want 7", res[0]); end
    tick();
    nvec++; if ({busy[0], done[0]} !== 2'b00) begin
      nmis++; $display("FAIL ignore_no_restart busy/done: got %b want 00", {busy[0], done[0]}); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int ndone;
    run_op(0, 3'b010, 32'd5, 32'd6, lat);
    nvec++; if (res[0] !== 32'd11) begin nmis++; $display("FAIL pre_reset_result: got %h want b", res[0]); end
    op = 3'b010; a = 32'h0000_FFFF; b = 32'd1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nvec++; if (busy[0] !== 1'b0) begin nmis++; $display("FAIL midreset_busy: got %b want 0", busy[0]); end
    nvec++; if (res[0] !== 32'h0) begin nmis++; $display("FAIL midreset_result: got %h want 0", res[0]); end
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done[0] !== 1'b0) ndone++;
      tick();
    end
    nvec++; if (ndone !== 0) begin nmis++; $display("FAIL midreset_no_done: got %0d pulses want 0", ndone); end
    reset = 1'b1;
    start[0] = 1'b1;
    tick();
    reset = 1'b0;
    start[0] = 1'b0;
    nvec++; if (busy[0] !== 1'b0) begin nmis++; $display("FAIL reset_over_start: got busy %b want 0", busy[0]); end
    run_op(0, 3'b010, 32'd1, 32'd1, lat);
    nvec++; if (res[0] !== 32'd2) begin nmis++; $display("FAIL after_reset_add: got %h want 2", res[0]); end
    nvec++; if (lat !== 4) begin nmis++; $display("FAIL after_reset_latency: got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int d = 0; d < 4; d++) begin
      run_op(d, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, lat);
      nvec++; if (lat !== nexp[d]) begin nmis++; $display("FAIL sweep%0d_latency: got %0d want %0d", d, lat, nexp[d]); end
      nvec++; if (res[d] !== 32'h0) begin nmis++; $display("FAIL sweep%0d_result: got %h want 0", d, res[d]); end
      nvec++; if ({cout[d], vout[d]} !== 2'b10) begin
        nmis++; $display("FAIL sweep%0d_flags CV: got %b want 10", d, {cout[d], vout[d]}); end
      // Still in the Done cycle here, so this Start must be accepted.
      run_op(d, 3'b010, 32'd2, 32'd3, lat);
      nvec++; if (lat !== nexp[d]) begin nmis++; $display("FAIL b2b%0d_latency: got %0d want %0d", d, lat, nexp[d]); end
      nvec++; if (res[d] !== 32'd5) begin nmis++; $display("FAIL b2b%0d_result: got %h want 5", d, res[d]); end
      nvec++; if (cout[d] !== 1'b0) begin nmis++; $display("FAIL b2b%0d_cout: got %b want 0", d, cout[d]); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    op = 3'b000;
    a = 32'h0;
    b = 32'h0;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_unsupported();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
